// File: rtl/id_fetch_buffer.sv
// Two-entry instruction buffer between fetch and decode.
// Decodes each instruction as it is pushed and presents the head entry from registered outputs.
module id_fetch_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [5:0]  out_opcode,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [5:0]  out_funct,
    output logic [15:0] Imm16_o,
    output logic [1:0]  EXTOp_o,
    output logic        out_illegal
);

    localparam logic [1:0] FULL     = 2'(DEPTH);
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_NONE = 2'b10;

    logic [31:0] inst_mem    [DEPTH];
    logic [31:0] pc_mem      [DEPTH];
    logic [1:0]  ext_mem     [DEPTH];
    logic        illegal_mem [DEPTH];

    logic        wr_ptr_reg, wr_ptr_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic [1:0]  count_reg,  count_next;

    logic [31:0] out_inst_reg;
    logic [31:0] out_pc_reg;
    logic [1:0]  out_ext_reg;
    logic        out_illegal_reg;

    logic        push, pop;
    logic [1:0]  in_ext;
    logic        in_illegal;
    logic        head_from_input;
    logic [31:0] head_inst_next;
    logic [31:0] head_pc_next;
    logic [1:0]  head_ext_next;
    logic        head_illegal_next;

    assign in_ready  = (count_reg != FULL);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        in_ext     = EXT_NONE;
        in_illegal = 1'b0;
        case (in_inst[31:26])
            6'b000100, 6'b000101, 6'b001000, 6'b001001,
            6'b001010, 6'b001011, 6'b100011, 6'b101011: in_ext = EXT_SIGN;
            6'b001100, 6'b001101, 6'b001110, 6'b001111: in_ext = EXT_ZERO;
            6'b000000, 6'b000010, 6'b000011:             in_ext = EXT_NONE;
            default:                                     in_illegal = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
            count_next  = 2'd0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    // The next head is the incoming word whenever it lands in an empty (or emptying) buffer.
    assign head_from_input = push && ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop));

    always_comb begin
        head_inst_next    = inst_mem[rd_ptr_next];
        head_pc_next      = pc_mem[rd_ptr_next];
        head_ext_next     = ext_mem[rd_ptr_next];
        head_illegal_next = illegal_mem[rd_ptr_next];
        if (head_from_input) begin
            head_inst_next    = in_inst;
            head_pc_next      = in_pc;
            head_ext_next     = in_ext;
            head_illegal_next = in_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    inst_mem[gi]    <= 32'd0;
                    pc_mem[gi]      <= 32'd0;
                    ext_mem[gi]     <= EXT_NONE;
                    illegal_mem[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    inst_mem[gi]    <= in_inst;
                    pc_mem[gi]      <= in_pc;
                    ext_mem[gi]     <= in_ext;
                    illegal_mem[gi] <= in_illegal;
                end
            end
        end
    endgenerate

    // Data outputs hold when the buffer drains; only the illegal flag is cleared.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_inst_reg    <= 32'd0;
            out_pc_reg      <= 32'd0;
            out_ext_reg     <= EXT_NONE;
            out_illegal_reg <= 1'b0;
        end else if (count_next != 2'd0) begin
            out_inst_reg    <= head_inst_next;
            out_pc_reg      <= head_pc_next;
            out_ext_reg     <= head_ext_next;
            out_illegal_reg <= head_illegal_next;
        end else begin
            out_illegal_reg <= 1'b0;
        end
    end

    assign out_pc      = out_pc_reg;
    assign out_opcode  = out_inst_reg[31:26];
    assign out_rs      = out_inst_reg[25:21];
    assign out_rt      = out_inst_reg[20:16];
    assign out_rd      = out_inst_reg[15:11];
    assign out_funct   = out_inst_reg[5:0];
    assign Imm16_o     = out_inst_reg[15:0];
    assign EXTOp_o     = out_ext_reg;
    assign out_illegal = out_illegal_reg;

endmodule

// File: doc/id_fetch_buffer.md
ID_FETCH_BUFFER -- requirements
Module: id_fetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning number of instruction buffer entries (legal values 2 only; other values unsupported).
REQ-002 The block SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  fetch stage presents an instruction.
REQ-005 in_inst  input  32  instruction word.
REQ-006 in_pc  input  32  PC of in_inst.
REQ-007 in_ready  output  1  buffer accepts an instruction this cycle.
REQ-008 flush  input  1  discard all buffered instructions (branch/jump redirect).
REQ-009 out_valid  output  1  head entry holds a decoded instruction.
REQ-010 out_ready  input  1  downstream (immediate extender/execute) consumes head this cycle.
REQ-011 out_pc  output  32  PC of head entry.
REQ-012 out_opcode  output  6  head inst[31:26]; out_rs 5 inst[25:21]; out_rt 5 inst[20:16]; out_rd 5 inst[15:11]; out_funct 6 inst[5:0].
REQ-013 Imm16_o  output  16  head inst[15:0], feeds extender Imm16_i.
REQ-014 EXTOp_o  output  2  extension select for extender: 00 zero, 01 sign, 10 none.
REQ-015 out_illegal  output  1  head opcode not in supported set.

Function
REQ-016 Push SHALL occur when in_valid and in_ready are both 1 and flush is 0; pop SHALL occur when out_valid and out_ready are both 1 and flush is 0.
REQ-017 Storage SHALL be a 2-entry circular FIFO: write pointer, read pointer (1 bit each, wrap 1->0) and count 0..2.
REQ-018 in_ready SHALL be (count != 2), derived from registered count only; no combinational path from out_ready to in_ready.
REQ-019 out_valid SHALL be (count != 0); all out_* fields, Imm16_o, EXTOp_o and out_illegal SHALL reflect the entry at read pointer.
REQ-020 Decode SHALL be computed at push time from in_inst and stored per entry; outputs SHALL change only on clock edges.
REQ-021 EXTOp SHALL be 01 for opcodes 000100 beq, 000101 bne, 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu, 100011 lw, 101011 sw.
REQ-022 EXTOp SHALL be 00 for opcodes 001100 andi, 001101 ori, 001110 xori, 001111 lui.
REQ-023 EXTOp SHALL be 10 for 000000 R-type, 000010 j, 000011 jal; out_illegal SHALL be 0 for all opcodes in REQ-021..023 and 1 otherwise, with EXTOp 10.
REQ-024 Latency: an instruction pushed in cycle N SHALL appear at outputs in cycle N+1 when buffer was empty; with one entry ahead, after that entry pops.
REQ-025 Simultaneous push and pop with count 1 SHALL leave count 1 and advance both pointers; order SHALL be strictly FIFO.
REQ-026 Simultaneous push and pop with count 2 cannot push (in_ready 0); count SHALL become 1.
REQ-027 Pop with count 0 and push with count 2 SHALL not occur by construction; pointers and count SHALL never wrap past their range.
REQ-028 flush=1 SHALL set count 0 and both pointers 0 on the next edge, overriding any simultaneous push or pop; the instruction presented that cycle is dropped.
REQ-029 When out_valid is 0, outputs SHALL hold their last values (don't-care to consumers); out_illegal SHALL be qualified by out_valid.

Reset
REQ-030 With rstn=0 at a rising edge, count, pointers SHALL become 0; out_valid SHALL be 0 and in_ready 1 in the following cycle.
REQ-031 After reset all out_* data, Imm16_o and out_illegal SHALL be 0 and EXTOp_o SHALL be 10.
REQ-032 Reset SHALL take priority over flush, push and pop; reset mid-stream SHALL discard all entries.

Verification
REQ-033 Reset, then push 0x2008FFFC (addi, pc 0x00400000), out_ready=0 -> next cycle out_valid=1, Imm16_o=0xFFFC, EXTOp_o=01, out_rt=8, out_pc=0x00400000.
REQ-034 Push 0x3508ABCD (ori) then 0x00851020 (add) with out_ready=0 -> count 2, in_ready=0; third in_valid ignored; pops return ori (EXTOp 00) then add (EXTOp 10, out_funct 0x20).
REQ-035 Continuous in_valid and out_ready=1 for 8 instructions -> one instruction per cycle, order and pc preserved, in_ready stays 1.
REQ-036 Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle instruction not delivered.
REQ-037 Push opcode 0x3F word 0xFC000000 -> out_illegal=1, EXTOp_o=10; rstn=0 while 2 entries held -> next cycle out_valid=0, EXTOp_o=10.
